// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: checker FSM states, default taps and the next-state function
// used by both the PRBS generator and the checker.
package lfsr_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    localparam int         LFSR_MAX_W   = 32;
    localparam logic [3:0] LFSR_TAPS_N4 = 4'b1100;   // x^4 + x^3 + 1

    // Callers zero-extend to LFSR_MAX_W and truncate the result back to N bits;
    // zero upper bits leave the parity untouched.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] cur,
        input logic [LFSR_MAX_W-1:0] taps
    );
        return {cur[LFSR_MAX_W-2:0], ^(cur & taps)};
    endfunction

endpackage

// File: rtl/lfsr_sat_counter.sv
// Saturating up-counter with synchronous clear; holds the checker's error count.
module lfsr_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_count <= '0;
        else if (i_clr)
            r_count <= '0;
        else if (i_inc && (r_count != {W{1'b1}}))
            r_count <= r_count + W'(1);
    end

    assign o_count = r_count;

endmodule

// File: rtl/lfsr_prbs_checker.sv
// Self-synchronising PRBS checker: HUNT -> VERIFY -> LOCKED with a flywheel predictor.
// Define LFSR_CHK_ZERO_ALARM_EN to reject all-zero seeds and expose zero_alarm.
module lfsr_prbs_checker
    import lfsr_pkg::*;
#(
    parameter int           N        = 4,
    parameter logic [N-1:0] TAPS     = N'(LFSR_TAPS_N4),
    parameter int           LOCK_CNT = 4,
    parameter int           LOSS_CNT = 3,
    parameter int           CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             data_valid,
    input  logic [N-1:0]     lfsr_data,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
`ifdef LFSR_CHK_ZERO_ALARM_EN
    ,
    output logic             zero_alarm
`endif
);

    localparam int MC_W = $clog2(LOCK_CNT + 1);
    localparam int LC_W = $clog2(LOSS_CNT + 1);

    chk_state_t      r_state, w_state_nxt;
    logic [N-1:0]    r_expected, w_exp_nxt;
    logic [MC_W-1:0] r_match_cnt, w_match_nxt;
    logic [LC_W-1:0] r_loss_cnt, w_loss_nxt;
    logic            r_err_pulse, w_pulse_nxt;
    logic            w_err_inc;
    logic            w_match;
    logic [N-1:0]    w_seed_nxt;
    logic [N-1:0]    w_fly_nxt;

    assign w_match    = (lfsr_data == r_expected);
    assign w_seed_nxt = N'(lfsr_next(LFSR_MAX_W'(lfsr_data), LFSR_MAX_W'(TAPS)));
    assign w_fly_nxt  = N'(lfsr_next(LFSR_MAX_W'(r_expected), LFSR_MAX_W'(TAPS)));

`ifdef LFSR_CHK_ZERO_ALARM_EN
    logic r_zero_alarm, w_zero_set;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_exp_nxt   = r_expected;
        w_match_nxt = r_match_cnt;
        w_loss_nxt  = r_loss_cnt;
        w_pulse_nxt = 1'b0;
        w_err_inc   = 1'b0;
`ifdef LFSR_CHK_ZERO_ALARM_EN
        w_zero_set  = 1'b0;
`endif
        if (clear) begin
            w_state_nxt = HUNT;
            w_match_nxt = '0;
            w_loss_nxt  = '0;
        end else if (data_valid) begin
`ifdef LFSR_CHK_ZERO_ALARM_EN
            // A zero word would seed a stuck all-zero prediction, so refuse it.
            if ((lfsr_data == '0) && (r_state != LOCKED)) begin
                w_state_nxt = HUNT;
                w_match_nxt = '0;
                w_zero_set  = 1'b1;
            end else
`endif
            case (r_state)
                HUNT: begin
                    w_exp_nxt   = w_seed_nxt;
                    w_match_nxt = '0;
                    w_state_nxt = VERIFY;
                end
                VERIFY: begin
                    w_exp_nxt = w_seed_nxt;
                    if (!w_match) begin
                        w_match_nxt = '0;
                    end else if (r_match_cnt == MC_W'(LOCK_CNT - 1)) begin
                        w_match_nxt = '0;
                        w_loss_nxt  = '0;
                        w_state_nxt = LOCKED;
                    end else begin
                        w_match_nxt = r_match_cnt + MC_W'(1);
                    end
                end
                LOCKED: begin
                    // Flywheel: predict from our own state so one bad word cannot reseed.
                    w_exp_nxt = w_fly_nxt;
                    if (w_match) begin
                        w_loss_nxt = '0;
                    end else begin
                        w_pulse_nxt = 1'b1;
                        w_err_inc   = 1'b1;
                        if (r_loss_cnt == LC_W'(LOSS_CNT - 1)) begin
                            w_loss_nxt  = '0;
                            w_state_nxt = HUNT;
                        end else begin
                            w_loss_nxt = r_loss_cnt + LC_W'(1);
                        end
                    end
                end
                default: w_state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= HUNT;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_expected  <= '0;
            r_match_cnt <= '0;
            r_loss_cnt  <= '0;
            r_err_pulse <= 1'b0;
        end else begin
            r_expected  <= w_exp_nxt;
            r_match_cnt <= w_match_nxt;
            r_loss_cnt  <= w_loss_nxt;
            r_err_pulse <= w_pulse_nxt;
        end
    end

`ifdef LFSR_CHK_ZERO_ALARM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_zero_alarm <= 1'b0;
        else if (clear)
            r_zero_alarm <= 1'b0;
        else if (w_zero_set)
            r_zero_alarm <= 1'b1;
    end

    assign zero_alarm = r_zero_alarm;
`endif

    lfsr_sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (clear),
        .i_inc   (w_err_inc),
        .o_count (err_count)
    );

    assign locked    = (r_state == LOCKED);
    assign err_pulse = r_err_pulse;

endmodule
